// File: rtl/abc_share_arb_pkg.sv
// Shared types and widths for the abc datapath round-robin sharing arbiter.
package abc_share_arb_pkg;

    // Operand widths of the shared abc datapath.
    localparam int unsigned A_W   = 2;
    localparam int unsigned B_W   = 3;

    // Width of the latency down-counter; covers LAT up to 15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;

    // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the last candidate is ptr itself.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % int'(N_REQ));
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    assign valid_o  = found;
    assign idx_o    = idx;
    assign onehot_o = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/abc_share_arb.sv
// Shares one abc datapath among N_REQ requesters with round-robin arbitration.
// One transaction at a time: IDLE -> ISSUE -> WAIT (LAT cycles total) -> RESP.
module abc_share_arb
    import abc_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ*A_W-1:0] req_a_i,
    input  logic [N_REQ*B_W-1:0] req_b_i,
    output logic [N_REQ-1:0]     gnt_o,
    output logic [A_W-1:0]       dp_a_o,
    output logic [B_W-1:0]       dp_b_o,
    output logic                 dp_go_o,
    input  logic                 dp_c_i,
    output logic [N_REQ-1:0]     rsp_valid_o,
    output logic                 rsp_c_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [A_W-1:0]     dp_a_q;
    logic [B_W-1:0]     dp_b_q;
    logic               dp_go_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic               rsp_c_q;
    logic               busy_q;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [A_W-1:0]     sel_a;
    logic [B_W-1:0]     sel_b;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Select the winner's operand slices with constant part-selects.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_a = req_a_i[k*A_W +: A_W];
                sel_b = req_b_i[k*B_W +: B_W];
            end
        end
    end

    // Transaction FSM; every output is a register updated on the state transition into it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
            idx_q       <= '0;
            gnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_go_q     <= 1'b0;
            rsp_valid_q <= '0;
            rsp_c_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q <= StIssue;
                        idx_q   <= pick_idx;
                        gnt_q   <= pick_onehot;
                        dp_a_q  <= sel_a;
                        dp_b_q  <= sel_b;
                        dp_go_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StIssue: begin
                    dp_go_q <= 1'b0;
                    cnt_q   <= CNT_W'(LAT - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        rsp_c_q     <= dp_c_i;
                        rsp_valid_q <= gnt_q;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    rsp_valid_q <= '0;
                    ptr_q       <= idx_q;
                    gnt_q       <= '0;
                    dp_a_q      <= '0;
                    dp_b_q      <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign dp_a_o      = dp_a_q;
    assign dp_b_o      = dp_b_q;
    assign dp_go_o     = dp_go_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_c_o     = rsp_c_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_abc_share_arb.sv
// Directed bench for abc_share_arb with N_REQ=4, LAT=2.
module tb_abc_share_arb;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LAT   = 2;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ*2-1:0] req_a_i;
    logic [N_REQ*3-1:0] req_b_i;
    logic [N_REQ-1:0]   gnt_o;
    logic [1:0]         dp_a_o;
    logic [2:0]         dp_b_o;
    logic               dp_go_o;
    logic               dp_c_i;
    logic [N_REQ-1:0]   rsp_valid_o;
    logic               rsp_c_o;
    logic               busy_o;

    int n_vec;
    int n_miss;

    abc_share_arb #(
        .N_REQ (N_REQ),
        .LAT   (LAT)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .gnt_o       (gnt_o),
        .dp_a_o      (dp_a_o),
        .dp_b_o      (dp_b_o),
        .dp_go_o     (dp_go_o),
        .dp_c_i      (dp_c_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_c_o     (rsp_c_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_gnt [5];
    logic [1:0] exp_a   [5];
    logic [2:0] exp_b   [5];

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rst_n   = 1'b0;
        req_i   = '0;
        req_a_i = '0;
        req_b_i = '0;
        dp_c_i  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_gnt",   32'(gnt_o),       32'h0);
        check_eq("rst_go",    32'(dp_go_o),     32'h0);
        check_eq("rst_busy",  32'(busy_o),      32'h0);
        check_eq("rst_rspv",  32'(rsp_valid_o), 32'h0);
        check_eq("rst_a",     32'(dp_a_o),      32'h0);

        // Single transaction from requester 0: cycle 0 is this IDLE cycle
        req_i   = 4'b0001;
        req_a_i = 8'b00_00_00_10;
        req_b_i = 12'b000_000_000_101;
        tick();                                     // cycle 1: ISSUE
        check_eq("t1_go",   32'(dp_go_o), 32'h1);
        check_eq("t1_a",    32'(dp_a_o),  32'h2);
        check_eq("t1_b",    32'(dp_b_o),  32'h5);
        check_eq("t1_gnt",  32'(gnt_o),   32'h1);
        check_eq("t1_busy", 32'(busy_o),  32'h1);
        req_i = '0;
        tick();                                     // cycle 2: WAIT
        check_eq("t2_go",   32'(dp_go_o), 32'h0);
        check_eq("t2_a",    32'(dp_a_o),  32'h2);
        dp_c_i = 1'b0;
        tick();                                     // cycle 3: WAIT, result sampled here
        dp_c_i = 1'b1;
        check_eq("t3_rspv", 32'(rsp_valid_o), 32'h0);
        tick();                                     // cycle 4: RESP
        check_eq("t4_rspv", 32'(rsp_valid_o), 32'h1);
        check_eq("t4_rspc", 32'(rsp_c_o),     32'h1);
        check_eq("t4_b",    32'(dp_b_o),      32'h5);
        tick();                                     // cycle 5: IDLE
        check_eq("t5_rspv", 32'(rsp_valid_o), 32'h0);
        check_eq("t5_gnt",  32'(gnt_o),       32'h0);
        check_eq("t5_busy", 32'(busy_o),      32'h0);
        check_eq("t5_a",    32'(dp_a_o),      32'h0);

        // All four requesting: order 0,1,2,3,0, five cycles apart
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        req_a_i = 8'b00_11_01_10;
        req_b_i = 12'b011_110_001_101;
        req_i   = 4'b1111;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_a   = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
        exp_b   = '{3'b101, 3'b001, 3'b110, 3'b011, 3'b101};
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("rr_gnt%0d", k), 32'(gnt_o),  32'(exp_gnt[k]));
            check_eq($sformatf("rr_a%0d", k),   32'(dp_a_o), 32'(exp_a[k]));
            check_eq($sformatf("rr_b%0d", k),   32'(dp_b_o), 32'(exp_b[k]));
            repeat (4) tick();
            check_eq($sformatf("rr_gap%0d", k), 32'(gnt_o),  32'h0);
        end
        req_i = '0;

        // Move ptr to 2, then 1001 must go to 3 and wrap to 0
        tick();
        req_i = 4'b0100;
        tick();
        check_eq("p2_gnt", 32'(gnt_o), 32'h4);
        req_i = '0;
        repeat (4) tick();
        req_i = 4'b1001;
        tick();
        check_eq("wr_gnt3", 32'(gnt_o), 32'h8);
        repeat (4) tick();
        tick();
        check_eq("wr_gnt0", 32'(gnt_o), 32'h1);
        req_i = '0;
        repeat (4) tick();

        // Request dropped mid-transaction still completes
        req_i = 4'b0100;
        tick();                                     // cycle 1
        check_eq("drop_gnt", 32'(gnt_o), 32'h4);
        tick();                                     // cycle 2
        req_i = '0;
        tick();                                     // cycle 3
        check_eq("drop_rspv3", 32'(rsp_valid_o), 32'h0);
        tick();                                     // cycle 4
        check_eq("drop_rspv4", 32'(rsp_valid_o), 32'h4);
        tick();
        check_eq("drop_rspv5", 32'(rsp_valid_o), 32'h0);

        // Reset during WAIT abandons the transaction
        dp_c_i = 1'b1;
        req_i  = 4'b0001;
        tick();                                     // ISSUE
        req_i = '0;
        tick();                                     // WAIT
        rst_n = 1'b0;
        tick();
        check_eq("mr_gnt",  32'(gnt_o),       32'h0);
        check_eq("mr_a",    32'(dp_a_o),      32'h0);
        check_eq("mr_b",    32'(dp_b_o),      32'h0);
        check_eq("mr_go",   32'(dp_go_o),     32'h0);
        check_eq("mr_rspv", 32'(rsp_valid_o), 32'h0);
        check_eq("mr_rspc", 32'(rsp_c_o),     32'h0);
        check_eq("mr_busy", 32'(busy_o),      32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("mr_norsp%0d", k), 32'(rsp_valid_o), 32'h0);
        end
        req_i = 4'b1010;
        tick();
        check_eq("mr_first_gnt", 32'(gnt_o), 32'h2);
        req_i = '0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/abc_share_arb.md
ABC_SHARE_ARB -- requirements
Module: abc_share_arb

Interface
REQ-001 Parameter N_REQ SHALL be: default 4; number of requesters sharing one abc datapath instance (2..8).
REQ-002 Parameter LAT SHALL be: default 2; datapath latency in cycles from go to valid signal_c (1..15).
REQ-003 Port clk SHALL be: input, 1 bit; single clock; all logic on its rising edge.
REQ-004 Port rst_n SHALL be: input, 1 bit; reset, synchronous, active-low.
REQ-005 Port req_i SHALL be: input, N_REQ bits; per-requester request level.
REQ-006 Port req_a_i SHALL be: input, N_REQ*2 bits; per-requester signal_a operand, requester k at bits [2k+1:2k].
REQ-007 Port req_b_i SHALL be: input, N_REQ*3 bits; per-requester signal_b operand, requester k at bits [3k+2:3k].
REQ-008 Port gnt_o SHALL be: output, N_REQ bits; one-hot grant, or zero.
REQ-009 Port dp_a_o SHALL be: output, 2 bits; to datapath signal_a.
REQ-010 Port dp_b_o SHALL be: output, 3 bits; to datapath signal_b.
REQ-011 Port dp_go_o SHALL be: output, 1 bit; one-cycle datapath start.
REQ-012 Port dp_c_i SHALL be: input, 1 bit; datapath signal_c result.
REQ-013 Port rsp_valid_o SHALL be: output, N_REQ bits; one-hot, one-cycle response strobe.
REQ-014 Port rsp_c_o SHALL be: output, 1 bit; captured result, valid with rsp_valid_o.
REQ-015 Port busy_o SHALL be: output, 1 bit; high whenever state is not IDLE.

Function
REQ-016 FSM SHALL have states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-017 IDLE SHALL pick, when req_i is nonzero, the first set bit searching upward from ptr+1 modulo N_REQ, and SHALL go to ISSUE.
REQ-018 On that IDLE->ISSUE edge the block SHALL latch the winner's req_a_i/req_b_i and SHALL set gnt_o to the winner's one-hot.
REQ-019 ISSUE SHALL last 1 cycle with dp_go_o=1 and dp_a_o/dp_b_o set to the latched operands, and SHALL load cnt=LAT-1 before going to WAIT.
REQ-020 WAIT SHALL decrement cnt each cycle; at cnt==0 it SHALL sample dp_c_i into rsp_c_o and go to RESP.
REQ-021 RESP SHALL last 1 cycle with rsp_valid_o=gnt_o; ptr SHALL become the granted index; next state SHALL be IDLE with gnt_o cleared.
REQ-022 dp_a_o/dp_b_o SHALL stay stable from ISSUE through RESP; they SHALL be 0 in IDLE.
REQ-023 Latency: req sampled in IDLE at cycle t SHALL give dp_go_o at t+1 and rsp_valid_o at t+2+LAT; the next grant SHALL occur no earlier than t+3+LAT.
REQ-024 A request that drops mid-transaction SHALL NOT abort it; the response SHALL still be issued.
REQ-025 Requests arriving while busy_o=1 SHALL wait; no request SHALL be lost if it is held.
REQ-026 ptr SHALL wrap from N_REQ-1 to 0.
REQ-027 A single persistent requester SHALL be regranted back-to-back every LAT+3 cycles.

Reset
REQ-028 With rst_n=0 at a clock edge, state SHALL become IDLE and cnt SHALL become 0.
REQ-029 The same reset edge SHALL set gnt_o, dp_a_o, dp_b_o, dp_go_o, rsp_valid_o, rsp_c_o and busy_o to 0.
REQ-030 The same reset edge SHALL set ptr=N_REQ-1, so requester 0 has first priority.
REQ-031 Reset during any state, including mid-WAIT, SHALL abandon the transaction with no rsp_valid_o.

Structure
REQ-032 Package abc_share_arb_pkg SHALL hold the state enum, A_W=2, B_W=3 and the LAT width constant.
REQ-033 Sub-module rr_pick SHALL implement the combinational round-robin picker (inputs req and ptr; outputs one-hot and index).

Verification (N_REQ=4, LAT=2)
REQ-034 After reset, req_i=0001, a0=2'b10, b0=3'b101 at cycle 0 SHALL give: dp_go_o=1 at cycle 1 with dp_a_o=10, dp_b_o=101; rsp_valid_o=0001 at cycle 4 with rsp_c_o=dp_c_i value of cycle 3.
REQ-035 req_i=1111 held SHALL give grants in order 0,1,2,3,0, each 5 cycles apart.
REQ-036 With ptr=2 and req_i=1001, the grant SHALL go to requester 3; the next grant SHALL go to requester 0 (wrap).
REQ-037 req_i=0100 dropped to 0000 in WAIT SHALL still give rsp_valid_o=0100 at its scheduled cycle.
REQ-038 rst_n=0 during WAIT SHALL give all outputs 0 on the next cycle and no rsp_valid_o; the first grant after reset with req_i=1010 SHALL go to requester 1.
